// File: rtl/piso_scan_driver_if.sv
// rtl/piso_scan_driver_if.sv - load handshake, hold control and serial scan outputs of piso_scan_driver
interface piso_scan_driver_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] PI;
   logic             load_valid;
   logic             load_ready;
   logic             hold;
   logic             SO;
   logic             shift_en;
   logic             busy;
   logic             done;
   logic [4:0]       bit_count;

   modport master (
      output PI, load_valid, hold,
      input  load_ready, SO, shift_en, busy, done, bit_count
   );

   modport slave (
      input  PI, load_valid, hold,
      output load_ready, SO, shift_en, busy, done, bit_count
   );
endinterface

// File: rtl/piso_scan_driver.sv
// rtl/piso_scan_driver.sv - parallel-in serial-out scan driver, MSB first, with hold and done pulse
module piso_scan_driver #(
   parameter int WIDTH = 16
) (
   input logic                C,
   input logic                piso_clear,
   piso_scan_driver_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             in_shift;

   assign in_shift = (state_q == ST_SHIFT);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_valid) begin
               sr_d    = bus.PI;
               cnt_d   = 5'd0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!bus.hold) begin
               sr_d  = {sr_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_BIT) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // bit_count reads WIDTH while done is high, then returns to 0 in IDLE
            cnt_d   = 5'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge C) begin
      if (piso_clear) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.load_ready = (state_q == ST_IDLE);
   assign bus.SO         = in_shift & sr_q[WIDTH-1];
   assign bus.shift_en   = in_shift & ~bus.hold;
   assign bus.busy       = in_shift | (state_q == ST_DONE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.bit_count  = cnt_q;
endmodule

// File: tb/tb_piso_scan_driver.sv
// tb/tb_piso_scan_driver.sv - self-checking bench for piso_scan_driver
module tb_piso_scan_driver;
   localparam int W = 16;

   logic C = 1'b0;
   logic piso_clear;
   int   n_checks = 0;
   int   n_fail   = 0;

   piso_scan_driver_if #(.WIDTH(W)) bus ();

   piso_scan_driver #(.WIDTH(W)) dut (
      .C          (C),
      .piso_clear (piso_clear),
      .bus        (bus.slave)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic test_reset();
      piso_clear     = 1'b1;
      bus.load_valid = 1'b1;
      bus.PI         = 16'($urandom);
      bus.hold       = 1'b1;
      tick();
      tick();
      piso_clear     = 1'b0;
      bus.load_valid = 1'b0;
      bus.hold       = 1'b0;
      #1;
      n_checks++;
      if ({bus.SO, bus.shift_en, bus.busy, bus.done, bus.load_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_outputs: SO/shift_en/busy/done/load_ready got %b want 00001",
                  {bus.SO, bus.shift_en, bus.busy, bus.done, bus.load_ready});
      end
      n_checks++;
      if (bus.bit_count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_bit_count: got %0d want 0", bus.bit_count);
      end
   endtask

   // Streams one word; hold is raised for hold_len cycles once hold_after bits have gone out.
   task automatic run_word(input logic [W-1:0] w, input int hold_after, input int hold_len,
                           input bit junk_en, input logic [W-1:0] junk);
      int           bits_sent = 0;
      int           held      = 0;
      int           done_cyc  = W + hold_len + 1;
      logic [W-1:0] sipo      = '0;
      logic         exp_hold;
      logic         exp_so;
      bus.PI         = w;
      bus.load_valid = 1'b1;
      bus.hold       = 1'b0;
      #1;
      n_checks++;
      if (bus.load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL load_ready_before_load: got %b want 1", bus.load_ready);
      end
      for (int c = 1; c <= done_cyc + 1; c++) begin
         tick();
         exp_hold       = (c < done_cyc) && (bits_sent == hold_after) && (held < hold_len);
         bus.hold       = (c < done_cyc) ? exp_hold : 1'($urandom);
         bus.load_valid = junk_en && (c <= done_cyc);
         bus.PI         = junk_en ? junk : w;
         #1;
         if (c < done_cyc) begin
            exp_so = w[W-1-bits_sent];
            n_checks++;
            if (bus.shift_en !== ~exp_hold || bus.SO !== exp_so || bus.bit_count !== 5'(bits_sent) ||
                bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.load_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL shift_cycle %0d word %h: got shift_en=%b SO=%b bit_count=%0d busy=%b done=%b load_ready=%b want %b %b %0d 1 0 0",
                        c, w, bus.shift_en, bus.SO, bus.bit_count, bus.busy, bus.done, bus.load_ready,
                        ~exp_hold, exp_so, bits_sent);
            end
            if (bus.shift_en) sipo = {sipo[W-2:0], bus.SO};
            if (exp_hold) held++;
            else bits_sent++;
         end else if (c == done_cyc) begin
            n_checks++;
            if (bus.done !== 1'b1 || bus.shift_en !== 1'b0 || bus.SO !== 1'b0 || bus.busy !== 1'b1 ||
                bus.load_ready !== 1'b0 || bus.bit_count !== 5'(W)) begin
               n_fail++;
               $display("FAIL done_cycle %0d word %h: got done=%b shift_en=%b SO=%b busy=%b load_ready=%b bit_count=%0d want 1 0 0 1 0 %0d",
                        c, w, bus.done, bus.shift_en, bus.SO, bus.busy, bus.load_ready, bus.bit_count, W);
            end
            n_checks++;
            if (sipo !== w) begin
               n_fail++;
               $display("FAIL sipo_loopback: got %h want %h", sipo, w);
            end
         end else begin
            n_checks++;
            if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.shift_en !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_after_word %h: got load_ready=%b busy=%b done=%b shift_en=%b want 1 0 0 0",
                        w, bus.load_ready, bus.busy, bus.done, bus.shift_en);
            end
         end
      end
      bus.load_valid = 1'b0;
      bus.hold       = 1'b0;
   endtask

   task automatic test_clear_mid();
      bit bad = 1'b0;
      bus.PI         = 16'h1234;
      bus.load_valid = 1'b1;
      bus.hold       = 1'b0;
      tick();
      bus.load_valid = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (bus.bit_count !== 5'd8 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_pre_bit_count: got %0d busy=%b want 8 1", bus.bit_count, bus.busy);
      end
      piso_clear = 1'b1;
      tick();
      piso_clear = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.SO, bus.shift_en, bus.done, bus.load_ready} !== 5'b00001 || bus.bit_count !== 5'd0) begin
         n_fail++;
         $display("FAIL clear_abort: busy/SO/shift_en/done/load_ready got %b bit_count=%0d want 00001 0",
                  {bus.busy, bus.SO, bus.shift_en, bus.done, bus.load_ready}, bus.bit_count);
      end
      repeat (W + 4) begin
         tick();
         if (bus.done !== 1'b0 || bus.shift_en !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL clear_no_done: got done or shift_en high after abort want both low");
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] stream = '0;
      int nbits = 0;
      int gap   = 0;
      int loads = 0;
      int cyc   = 0;
      bus.hold = 1'b0;
      while (cyc < 100) begin
         bus.PI         = (loads == 0) ? 16'hBEEF : 16'hCAFE;
         bus.load_valid = (nbits < 2 * W);
         #1;
         if (bus.load_ready && bus.load_valid) loads++;
         if (bus.shift_en) begin
            stream = {stream[2*W-2:0], bus.SO};
            nbits++;
         end else if (nbits == W) begin
            gap++;
         end
         if (nbits == 2 * W && !bus.busy) break;
         tick();
         cyc++;
      end
      bus.load_valid = 1'b0;
      n_checks++;
      if (cyc >= 100) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d bits after %0d cycles want %0d", nbits, cyc, 2 * W);
      end
      n_checks++;
      if (stream !== {16'hBEEF, 16'hCAFE}) begin
         n_fail++;
         $display("FAIL b2b_stream: got %h want beefcafe", stream);
      end
      n_checks++;
      if (gap !== 2) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d idle cycles want 2", gap);
      end
      n_checks++;
      if (loads !== 2) begin
         n_fail++;
         $display("FAIL b2b_loads: got %0d want 2", loads);
      end
      tick();
   endtask

   task automatic test_random();
      repeat (8) begin
         run_word(16'($urandom), $urandom_range(0, W - 1), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 16'($urandom));
      end
   endtask

   initial begin
      piso_clear     = 1'b1;
      bus.PI         = '0;
      bus.load_valid = 1'b0;
      bus.hold       = 1'b0;
      test_reset();
      run_word(16'hA5C3, 0, 0, 1'b0, 16'h0000);
      run_word(16'hFFFF, 4, 3, 1'b0, 16'h0000);
      run_word(16'h00FF, 0, 0, 1'b1, 16'hFF00);
      test_clear_mid();
      test_back_to_back();
      run_word(16'h1234, 0, 0, 1'b0, 16'h0000);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
